// File: rtl/led_cube_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_cube_pkg
// Purpose : Shared types and constants for the LED-cube byte-stream side.
//           Holds the system mode encoding, the stream marker bytes and the
//           framer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package led_cube_pkg;

  // System mode values. Only the stream mode enables the framer.
  typedef enum logic [3:0] {
    M_OFF    = 4'h0,
    M_TEST   = 4'h1,
    M_ANIM   = 4'h2,
    M_STREAM = 4'h3
  } led_mode_e;

  localparam logic [3:0] c_MODE_STREAM = M_STREAM;

  // Stream marker bytes
  localparam logic [7:0] c_SOF_BYTE  = 8'h20;
  localparam logic [7:0] c_CONT_BYTE = 8'h30;
  localparam logic [7:0] c_END_BYTE  = 8'h00;

  // Framer states. ST_CKSUM is only entered in the checksum build.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_TRAILER = 3'd4
  } framer_state_e;

endpackage
`default_nettype wire

// File: rtl/led_cube_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : led_cube_skid_buf
// Purpose : Two-entry byte FIFO that absorbs the one-cycle frame-buffer read
//           latency between the RAM read port and the byte link.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           i_flush         drop all held bytes
//           i_push, i_data  write one byte (caller guarantees space)
//           i_pop           consume the head byte
//           o_valid, o_data head byte present / head byte
//           o_count         number of held bytes (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module led_cube_skid_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic [1:0] o_count
);

  logic [7:0] r_mem [0:1];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= 8'h00;
      r_mem[1] <= 8'h00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/led_cube_stream_framer.sv
`default_nettype none
// ============================================================================
// Module  : led_cube_stream_framer
// Purpose : Transmit side of the LED-cube byte stream. While mode is the
//           stream mode, emits frames: SOF, FRAME_BYTES payload bytes read
//           from the frame buffer, [checksum], then a CONT or END trailer.
// Config  : `define LED_CUBE_FRAMER_CHECKSUM_EN inserts an XOR checksum byte
//           between the last payload byte and the trailer.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           mode, start           system mode, frame request (level)
//           fb_rd_en, fb_addr     frame-buffer read strobe / byte address
//           fb_rd_data            read data, valid 1 cycle after fb_rd_en
//           tx_data, tx_valid     outgoing byte / valid
//           tx_ready              sink accept
//           busy                  frame in progress (SOF .. trailer accept)
//           frame_done            1-cycle pulse on trailer accept
// Revision: 1.0 - initial release
// ============================================================================
module led_cube_stream_framer
  import led_cube_pkg::*;
#(
  parameter int          FRAME_BYTES = 64,
  parameter logic [7:0]  SOF_BYTE    = c_SOF_BYTE,
  parameter logic [7:0]  CONT_BYTE   = c_CONT_BYTE,
  parameter logic [7:0]  END_BYTE    = c_END_BYTE,
  parameter logic [3:0]  MODE_STREAM = c_MODE_STREAM,
  parameter int          AW          = $clog2(FRAME_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    mode,
  input  logic          start,
  output logic          fb_rd_en,
  output logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_rd_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [AW:0]   c_RD_TOTAL = (AW+1)'(FRAME_BYTES);
  localparam logic [AW-1:0] c_LAST_IDX = AW'(FRAME_BYTES - 1);

  framer_state_e r_state;
  framer_state_e w_next;

  logic [AW:0]   r_rd_cnt;    // reads issued this frame
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_tx_cnt;    // payload bytes accepted this frame
  logic          r_rd_pend;   // fb_rd_data carries a wanted byte this cycle
  logic          r_cont;      // trailer decision latched on TRAILER entry
`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
  logic [7:0]    r_cksum;
`endif

  logic       w_mode_ok, w_abort, w_tx_valid, w_accept, w_pop, w_bypass;
  logic       w_push, w_room, w_rd_go, w_last, w_head_valid;
  logic [7:0] w_head_data;
  logic       w_sb_valid;
  logic [7:0] w_sb_data;
  logic [1:0] w_sb_count;

  assign w_mode_ok = (mode == MODE_STREAM);
  assign w_abort   = (r_state != ST_IDLE) && !w_mode_ok;

  // Payload head: buffered byte first, otherwise the RAM byte arriving now.
  // Taking the RAM byte straight through removes the bubble after SOF.
  assign w_head_valid = w_sb_valid || r_rd_pend;
  assign w_head_data  = w_sb_valid ? w_sb_data : fb_rd_data;

  assign w_tx_valid = (r_state == ST_SOF) || (r_state == ST_CKSUM) ||
                      (r_state == ST_TRAILER) ||
                      ((r_state == ST_PAYLOAD) && w_head_valid);
  assign w_accept   = w_tx_valid && tx_ready;
  assign w_pop      = (r_state == ST_PAYLOAD) && w_accept;
  assign w_bypass   = w_pop && !w_sb_valid;
  assign w_push     = r_rd_pend && !w_bypass;

  // Issue a read only if the byte it returns next cycle will have a slot:
  // held + in-flight - leaving must stay below the buffer depth.
  assign w_room  = ({1'b0, w_sb_count} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop});
  assign w_rd_go = (r_rd_cnt != c_RD_TOTAL) && w_room && (w_sb_count != 2'd2);
  assign w_last  = (r_tx_cnt == c_LAST_IDX);

  led_cube_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (fb_rd_data),
    .i_pop   (w_pop),
    .o_valid (w_sb_valid),
    .o_data  (w_sb_data),
    .o_count (w_sb_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    tx_data    = 8'h00;
    fb_rd_en   = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mode_ok && start) w_next = ST_SOF;
      end
      ST_SOF: begin
        tx_data  = SOF_BYTE;
        fb_rd_en = w_rd_go;
        if (w_accept) w_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_data  = w_head_data;
        fb_rd_en = w_rd_go;
        if (w_accept && w_last) begin
`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
          w_next = ST_CKSUM;
`else
          w_next = ST_TRAILER;
`endif
        end
      end
`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
      ST_CKSUM: begin
        tx_data = r_cksum;
        if (w_accept) w_next = ST_TRAILER;
      end
`endif
      ST_TRAILER: begin
        tx_data = r_cont ? CONT_BYTE : END_BYTE;
        if (w_accept) begin
          frame_done = 1'b1;
          w_next     = r_cont ? ST_SOF : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next     = ST_IDLE;
      fb_rd_en   = 1'b0;
      frame_done = 1'b0;
    end
  end

  assign tx_valid = w_tx_valid;
  assign busy     = (r_state != ST_IDLE);
  assign fb_addr  = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_addr    <= '0;
      r_tx_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_cont    <= 1'b0;
    end else if (w_abort) begin
      // Clearing r_rd_pend discards any read still returning from RAM.
      r_rd_cnt  <= '0;
      r_addr    <= '0;
      r_tx_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_cont    <= 1'b0;
    end else begin
      r_rd_pend <= fb_rd_en;
      if (fb_rd_en) begin
        r_addr   <= r_addr + AW'(1);
        r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
      end else if ((r_state != ST_SOF) && (r_state != ST_PAYLOAD)) begin
        r_rd_cnt <= '0;
      end
      // Wraps to 0 after the last byte since FRAME_BYTES is a power of 2.
      if (w_pop) r_tx_cnt <= r_tx_cnt + AW'(1);
      if ((r_state != ST_TRAILER) && (w_next == ST_TRAILER)) begin
        r_cont <= w_mode_ok && start;
      end
    end
  end

`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cksum <= 8'h00;
    end else if (r_state == ST_SOF) begin
      r_cksum <= 8'h00;
    end else if (w_pop) begin
      r_cksum <= r_cksum ^ w_head_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_cube_stream_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_cube_stream_framer
// Purpose : Directed self-checking bench for led_cube_stream_framer with a
//           one-cycle-latency frame-buffer model and a byte capture monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_cube_stream_framer;

  localparam int FB = 64;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic [3:0]    mode;
  logic          start;
  logic          fb_rd_en;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;

  logic [7:0] mem [FB];
  int         n_total = 0;
  int         n_bad   = 0;
  int         n_done  = 0;
  int         cyc     = 0;
  bit         rand_en = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_data;
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int         cyc_q [$];

  led_cube_stream_framer #(.FRAME_BYTES(FB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .start      (start),
    .fb_rd_en   (fb_rd_en),
    .fb_addr    (fb_addr),
    .fb_rd_data (fb_rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-buffer RAM: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    fb_rd_data <= fb_rd_en ? mem[fb_addr] : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Capture monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(stall_data));
      end
      if (tx_valid && tx_ready) begin
        cap_q.push_back(tx_data);
        cyc_q.push_back(cyc);
      end
      if (frame_done) n_done++;
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int k = 0;
    while (n_done < target && k < limit) begin
      tick(1);
      k++;
    end
    if (n_done < target) check("timeout_done", 32'(n_done), 32'(target));
  endtask

  task automatic wait_cap(input int target, input int limit);
    int k = 0;
    while (cap_q.size() < target && k < limit) begin
      tick(1);
      k++;
    end
    if (cap_q.size() < target) check("timeout_cap", 32'(cap_q.size()), 32'(target));
  endtask

  task automatic clear_q();
    cap_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
  function automatic logic [7:0] xor_mem();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < FB; i++) x ^= mem[i];
    return x;
  endfunction
`endif

  task automatic build_exp(input bit cont);
    exp_q.push_back(8'h20);
    for (int i = 0; i < FB; i++) exp_q.push_back(mem[i]);
`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
    exp_q.push_back(xor_mem());
`endif
    exp_q.push_back(cont ? 8'h30 : 8'h00);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 4'h3;
    for (int i = 0; i < FB; i++) mem[i] = 8'(i);
    tick(3);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single frame, sink always ready
    clear_q();
    pulse_start();
    wait_done(1, 500);
    tick(3);
    build_exp(1'b0);
    compare_seq("single");
    if (cyc_q.size() == exp_q.size())
      check("single_contig", 32'(cyc_q[cyc_q.size()-1] - cyc_q[0]), 32'(exp_q.size() - 1));
    check("single_done", 32'(n_done), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_addr", 32'(fb_addr), 32'd0);

    // Back-to-back frames while start held
    clear_q();
    start = 1'b1;
    wait_done(2, 500);
    start = 1'b0;
    wait_done(3, 500);
    tick(3);
    build_exp(1'b1);
    build_exp(1'b0);
    compare_seq("b2b");
    if (cyc_q.size() == exp_q.size())
      check("b2b_no_gap", 32'(cyc_q[exp_q.size()/2] - cyc_q[exp_q.size()/2 - 1]), 32'd1);
    check("b2b_done", 32'(n_done), 32'd3);

    // Random sink back-pressure
    clear_q();
    rand_en = 1'b1;
    pulse_start();
    wait_done(4, 2000);
    rand_en = 1'b0;
    tick(3);
    build_exp(1'b0);
    compare_seq("rand");

    // Mode leaves stream mode mid-payload
    clear_q();
    pulse_start();
    wait_cap(11, 200);
    mode = 4'h1;
    tick(1);
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(fb_rd_en), 32'd0);
    check("abort_addr", 32'(fb_addr), 32'd0);
    tick(3);
    check("abort_no_done", 32'(n_done), 32'd4);
    pulse_start();
    tick(2);
    check("start_ignored_busy", 32'(busy), 32'd0);
    mode = 4'h3;
    tick(1);
    clear_q();
    pulse_start();
    wait_done(5, 500);
    tick(3);
    build_exp(1'b0);
    compare_seq("restart");

    // Asynchronous reset mid-payload
    for (int i = 0; i < FB; i++) mem[i] = 8'(8'hFF - 8'(i));
    clear_q();
    pulse_start();
    wait_cap(21, 200);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("arst_fb_addr", 32'(fb_addr), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_q();
    pulse_start();
    wait_done(6, 500);
    tick(3);
    build_exp(1'b0);
    compare_seq("post_rst");

`ifdef LED_CUBE_FRAMER_CHECKSUM_EN
    for (int i = 0; i < FB; i++) mem[i] = 8'hA5;
    clear_q();
    pulse_start();
    wait_done(7, 500);
    tick(3);
    build_exp(1'b0);
    compare_seq("ck_a5");
    if (cap_q.size() > FB + 1) check("ck_a5_byte", 32'(cap_q[FB+1]), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
